aes_inv_cipher: RTL and testbench
=================================

// Module: aes_inv_cipher
// PURPOSE
//  Iterative AES-128 inverse cipher (FIPS-197 InvCipher). Counterpart of aes_top encryptor.
//  Accepts a 128-bit ciphertext and cipher key, computes one round per clock and returns the plaintext.
//  Sits beside aes_top so decryption shares the same start/key/block interface.
// PARAMETERS
//  NUM_ROUNDS  10   AES-128 round count; only 10 supported
//  BLOCK_W     128  block and key width; only 128 supported
// PORTS
//  clk         in   1    rising-edge clock, single domain
//  reset       in   1    synchronous, active-low
//  start       in   1    one-cycle request; ciphertext/key sampled on the same edge
//  ciphertext  in   128  input block, byte 0 = bits [127:120]
//  key         in   128  cipher key (encryption key, not pre-inverted)
//  plaintext   out  128  result register, held until the next completion
//  busy        out  1    high from the edge after start is accepted until done
//  done        out  1    one-cycle pulse; plaintext valid from this cycle
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, plaintext=0, busy=0, done=0, round counter=0, key cache invalid.
//  FSM:
//   IDLE   start=1 -> latch ct, key into rk[0] -> EXPAND
//          (or -> INIT on a cache hit, with KEY_CACHE_EN).
//   EXPAND 10 cycles; cycle i computes rk[i] from rk[i-1] (RotWord/SubWord/Rcon 01..36). After rk[10] -> INIT.
//   INIT   state <= ct ^ rk[10]; rnd <= 9 -> ROUND.
//   ROUND  state <= InvShiftRows, InvSubBytes, AddRoundKey rk[rnd], then InvMixColumns if rnd!=0.
//          rnd decrements. At rnd==0: plaintext <= result; done <= 1; -> IDLE.
//  busy = (state != IDLE). done is high for exactly one cycle, in the first IDLE cycle.
//  Latency without a cache hit: start accepted at edge E0, done high after edge E21 (21 cycles).
//  start while busy is ignored; no queuing. start during the done cycle is accepted.
//  Round keys are stored as 11 x 128-bit registers; InvSubBytes uses a combinational inverse S-box (16 copies).
//  rk[] is kept after completion; ciphertext input is not tracked after sampling.
//  Reset mid-operation aborts immediately: no done, and plaintext is cleared to 0.
// CONFIGURATION
//  KEY_CACHE_EN defined:
//   - Keeps a 128-bit last_key register and a key_valid flag, set when EXPAND completes.
//   - On start with key==last_key && key_valid: skip EXPAND and go IDLE -> INIT; done after E11.
//   - Reset clears key_valid.
//  KEY_CACHE_EN undefined:
//   - Every start runs EXPAND; latency is always 21.
//   - No last_key or key_valid logic is built.
// TESTING
//  1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//     -> pt 00112233445566778899aabbccddeeff, done 21 cycles after start.
//  2. SP800-38A ECB: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3ad77bb40d7a3660a89ecaf32466ef97
//     -> pt 6bc1bee22e409f96e93d7e117393172a.
//     Then ct f5d3d58503b9699de785895a96fdbaaf with the same key
//     -> pt ae2d8a571e03ac9c9eb76fac45af8e51, latency 11 with KEY_CACHE_EN, 21 without.
//  3. Zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> pt all-zero; busy high for exactly 21 cycles.
//  4. Assert start 5 cycles into vector 1 with other data -> ignored; vector 1 result is unchanged.
//     Assert start in the done cycle -> second job accepted, busy next cycle.
//  5. reset=0 at cycle 8 of a job -> busy=0, done never pulses, plaintext=0.
//     Rerun vector 1 with KEY_CACHE_EN -> full 21-cycle latency (cache invalidated).
//  6. Back-to-back random keys and blocks against a reference model (encrypt with aes_top, then decrypt).
//     -> round-trip equals the original plaintext for 1000 vectors.

Source files
------------

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one key-expansion step or one inverse round per clock.
// Optional feature macro: KEY_CACHE_EN. When defined, the block remembers the last fully
// expanded key and skips the expansion phase on a start that presents the same key again.
module aes_inv_cipher #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned BLOCK_W    = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BLOCK_W-1:0] ciphertext,
    input  logic [BLOCK_W-1:0] key,
    output logic [BLOCK_W-1:0] plaintext,
    output logic               busy,
    output logic               done
);

    localparam int unsigned RND_W = 4;
    localparam int unsigned NB    = BLOCK_W / 8;

    typedef enum logic [1:0] {IDLE, EXPAND, INIT, ROUND} state_t;

    state_t             state;
    logic [RND_W-1:0]   rnd;
    logic [BLOCK_W-1:0] ct_q;
    logic [BLOCK_W-1:0] blk;
    logic [BLOCK_W-1:0] rk [0:NUM_ROUNDS];
    logic [RND_W-1:0]   key_idx;
    logic [BLOCK_W-1:0] key_sel;
    logic [BLOCK_W-1:0] expand_key;
    logic [BLOCK_W-1:0] round_out;

`ifdef KEY_CACHE_EN
    logic [BLOCK_W-1:0] last_key;
    logic               key_valid;
`endif

    // GF(2^8) multiply by x modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One forward key-schedule step: rk[i] from rk[i-1]
    function automatic logic [BLOCK_W-1:0] key_step(input logic [BLOCK_W-1:0] k,
                                                    input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns
    function automatic logic [BLOCK_W-1:0] inv_round(input logic [BLOCK_W-1:0] s,
                                                     input logic [BLOCK_W-1:0] k,
                                                     input logic mix);
        logic [7:0] b [NB];
        logic [7:0] t [NB];
        logic [7:0] a0, a1, a2, a3;
        logic [BLOCK_W-1:0] r;
        for (int j = 0; j < 16; j++) b[j] = s[BLOCK_W-1-8*j -: 8];
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                t[row+4*c] = inv_sbox(b[row + 4*((c + 4 - row) % 4)]) ^ k[BLOCK_W-1-8*(row+4*c) -: 8];
            end
        end
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                t[4*c]   = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
                t[4*c+1] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
                t[4*c+2] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
                t[4*c+3] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
            end
        end
        r = '0;
        for (int j = 0; j < 16; j++) r[BLOCK_W-1-8*j -: 8] = t[j];
        return r;
    endfunction

    // Round-key read port: previous key while expanding, current round key otherwise
    always_comb begin
        key_idx = (state == EXPAND) ? rnd - RND_W'(1) : rnd;
        key_sel = '0;
        for (int i = 0; i <= int'(NUM_ROUNDS); i++) begin
            if (key_idx == RND_W'(i)) key_sel = rk[i];
        end
    end

    // Shared datapath for the expansion step and the inverse round
    always_comb begin
        expand_key = key_step(key_sel, rcon(rnd));
        round_out  = inv_round(blk, key_sel, rnd != '0);
    end

    // Control FSM with registered outputs, round-key store and block state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            rnd       <= '0;
            plaintext <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef KEY_CACHE_EN
            key_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ct_q  <= ciphertext;
                        rk[0] <= key;
                        busy  <= 1'b1;
`ifdef KEY_CACHE_EN
                        if (key_valid && (key == last_key)) begin
                            state <= INIT;
                        end else begin
                            state <= EXPAND;
                            rnd   <= RND_W'(1);
                        end
`else
                        state <= EXPAND;
                        rnd   <= RND_W'(1);
`endif
                    end
                end
                EXPAND: begin
                    for (int i = 1; i <= int'(NUM_ROUNDS); i++) begin
                        if (rnd == RND_W'(i)) rk[i] <= expand_key;
                    end
                    if (rnd == RND_W'(NUM_ROUNDS)) begin
                        state <= INIT;
`ifdef KEY_CACHE_EN
                        last_key  <= rk[0];
                        key_valid <= 1'b1;
`endif
                    end else begin
                        rnd <= rnd + RND_W'(1);
                    end
                end
                INIT: begin
                    blk   <= ct_q ^ rk[NUM_ROUNDS];
                    rnd   <= RND_W'(NUM_ROUNDS - 1);
                    state <= ROUND;
                end
                ROUND: begin
                    blk <= round_out;
                    if (rnd == '0) begin
                        plaintext <= round_out;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        rnd <= rnd - RND_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher: known-answer vectors, control corner cases and a
// randomized round trip through a byte-level forward AES model.
module tb_aes_inv_cipher;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_err;

    logic [7:0]   sbox [256];
    logic [127:0] model_last_key;
    logic         model_key_valid;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2A = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P2A = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2B = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] P2B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_inv_cipher dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ciphertext (ciphertext),
        .key        (key),
        .plaintext  (plaintext),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box generated by walking the generator 3 and its inverse in lockstep
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        for (int n = 0; n < 255; n++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end
        sbox[0] = 8'h63;
    endtask

    // Forward AES-128 cipher on a byte array, used to build round-trip vectors
    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int j = 0; j < 16; j++) s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int j = 0; j < 16; j++) t[j] = sbox[s[j]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row+4*col] = t[row + 4*((col+row)%4)];
            if (r != 10) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
        end
        for (int j = 0; j < 16; j++) out[127-8*j -: 8] = s[j];
        return out;
    endfunction

    // Expected latency from the key-cache model
    function automatic int exp_latency(input logic [127:0] k);
`ifdef KEY_CACHE_EN
        if (model_key_valid && (k == model_last_key)) return 11;
`endif
        return 21;
    endfunction

    task automatic note_done(input logic [127:0] k);
        model_last_key  = k;
        model_key_valid = 1'b1;
    endtask

    // Present one job and wait for done; lat = -1 on timeout
    task automatic run_job(input logic [127:0] c, input logic [127:0] k,
                           output logic [127:0] pt, output int lat);
        start      = 1'b1;
        ciphertext = c;
        key        = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        pt = plaintext;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        ciphertext = '0;
        key = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (plaintext !== 128'h0) begin
            n_err++;
            $display("FAIL reset_plaintext: got %h want 0", plaintext);
        end
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%b done=%b want 0/0", busy, done);
        end
        reset = 1'b1;
        model_key_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_flags: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_fips();
        logic [127:0] pt;
        int lat;
        int exp_lat;
        exp_lat = exp_latency(K1);
        run_job(C1, K1, pt, lat);
        note_done(K1);
        n_cmp++;
        if (pt !== P1) begin
            n_err++;
            $display("FAIL fips_pt: got %h want %h", pt, P1);
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL fips_latency: got %0d want %0d", lat, exp_lat);
        end
    endtask

    task automatic test_sp800();
        logic [127:0] pt;
        int lat;
        int exp_lat;
        exp_lat = exp_latency(K2);
        run_job(C2A, K2, pt, lat);
        note_done(K2);
        n_cmp++;
        if (pt !== P2A || lat !== exp_lat) begin
            n_err++;
            $display("FAIL sp800_a: got pt=%h lat=%0d want pt=%h lat=%0d", pt, lat, P2A, exp_lat);
        end
        exp_lat = exp_latency(K2);
        run_job(C2B, K2, pt, lat);
        note_done(K2);
        n_cmp++;
        if (pt !== P2B) begin
            n_err++;
            $display("FAIL sp800_b_pt: got %h want %h", pt, P2B);
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL sp800_b_latency: got %0d want %0d", lat, exp_lat);
        end
    endtask

    task automatic test_zero_key();
        int n;
        start = 1'b1;
        ciphertext = C3;
        key = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        note_done('0);
        n_cmp++;
        if (n !== 21) begin
            n_err++;
            $display("FAIL zero_busy_cycles: got %0d want 21", n);
        end
        n_cmp++;
        if (done !== 1'b1 || plaintext !== 128'h0) begin
            n_err++;
            $display("FAIL zero_result: got done=%b pt=%h want done=1 pt=0", done, plaintext);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int exp_lat;
        logic [127:0] pt;
        exp_lat = exp_latency(K1);
        start = 1'b1;
        ciphertext = C1;
        key = K1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            start = (n == 5);
            if (n == 5) begin
                ciphertext = C2A;
                key = K2;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        note_done(K1);
        n_cmp++;
        if (plaintext !== P1 || lat !== exp_lat) begin
            n_err++;
            $display("FAIL ignore_busy_start: got pt=%h lat=%0d want pt=%h lat=%0d",
                     plaintext, lat, P1, exp_lat);
        end
        exp_lat = exp_latency(K2);
        run_job(C2A, K2, pt, lat);
        note_done(K2);
        n_cmp++;
        if (pt !== P2A || lat !== exp_lat) begin
            n_err++;
            $display("FAIL done_cycle_start: got pt=%h lat=%0d want pt=%h lat=%0d", pt, lat, P2A, exp_lat);
        end
        start = 1'b1;
        ciphertext = C1;
        key = K1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL accept_after_done: got busy=%b done=%b want 1/0", busy, done);
        end
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        note_done(K1);
        n_cmp++;
        if (plaintext !== P1 || lat < 0) begin
            n_err++;
            $display("FAIL second_job_result: got pt=%h lat=%0d want pt=%h", plaintext, lat, P1);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        int exp_lat;
        logic [127:0] pt;
        start = 1'b1;
        ciphertext = C1;
        key = K1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_key_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || plaintext !== 128'h0) begin
            n_err++;
            $display("FAIL abort_state: got busy=%b done=%b pt=%h want 0/0/0", busy, done, plaintext);
        end
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        n_cmp++;
        if (pulses !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: got pulses=%0d busy=%b want 0/0", pulses, busy);
        end
        exp_lat = exp_latency(K1);
        run_job(C1, K1, pt, lat);
        note_done(K1);
        n_cmp++;
        if (pt !== P1 || lat !== exp_lat || exp_lat !== 21) begin
            n_err++;
            $display("FAIL rerun_after_abort: got pt=%h lat=%0d want pt=%h lat=21", pt, lat, P1);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] c;
        logic [127:0] pt;
        int lat;
        int exp_lat;
        int bad;
        k = '0;
        bad = 0;
        for (int v = 0; v < 1000; v++) begin
            if (v == 0 || $urandom_range(0, 3) != 0)
                k = {$urandom(), $urandom(), $urandom(), $urandom()};
            p = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = aes_encrypt(p, k);
            exp_lat = exp_latency(k);
            run_job(c, k, pt, lat);
            note_done(k);
            n_cmp++;
            if (pt !== p || lat !== exp_lat) begin
                n_err++;
                bad++;
                if (bad <= 10)
                    $display("FAIL roundtrip[%0d]: got pt=%h lat=%0d want pt=%h lat=%0d",
                             v, pt, lat, p, exp_lat);
            end
            if (lat < 0) break;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_last_key = '0;
        model_key_valid = 1'b0;
        build_sbox();
        test_reset();
        test_fips();
        test_sp800();
        test_zero_key();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
